uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_os_tick.sv | 28 ++
 rtl/uart_rx_param.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM state encoding,
// parity mode constants and the 2-of-3 vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Sample-tick enable generator: one-cycle tick every CLK_DIV clk cycles
// (constantly high when CLK_DIV is 1).
module uart_os_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick      = (div_cnt_q == CW'(CLK_DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable frame format and a one-deep
// output holding register. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 dataerror,
    output logic                 frameerror,
    output logic                 overrun,
    output logic                 breakdet
);

    localparam int MID = OVERSAMPLE / 2;
    localparam int PW  = $clog2(OVERSAMPLE);

    logic tick;

    uart_os_tick #(.CLK_DIV(CLK_DIV)) u_os_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_sync_q, rx_sync_d;
    logic                 rx_prev_q, rx_prev_d;
    rx_state_t            state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 samp_mid_q, samp_mid_d;
`ifdef UART_RX_MAJORITY_EN
    logic                 samp_early_q, samp_early_d;
`endif
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_err_q, par_err_d;
    logic                 stop_err_q, stop_err_d;
    logic                 any_high_q, any_high_d;
    logic [DATA_BITS-1:0] dataout_q, dataout_d;
    logic                 valid_q, valid_d;
    logic                 dataerror_q, dataerror_d;
    logic                 frameerror_q, frameerror_d;
    logic                 overrun_q, overrun_d;
    logic                 breakdet_q, breakdet_d;

    logic fall;
    logic bit_val;
    logic stop_err_now;
    logic any_high_now;

    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        fall      = rx_prev_q & ~rx_sync_q;

        // The bit decision is taken one tick after mid-bit in both builds so
        // that enabling the vote does not change frame latency.
`ifdef UART_RX_MAJORITY_EN
        bit_val = maj3(samp_early_q, samp_mid_q, rx_sync_q);
`else
        bit_val = samp_mid_q;
`endif
        stop_err_now = stop_err_q | ~bit_val;
        any_high_now = any_high_q | bit_val;

        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        samp_mid_d   = samp_mid_q;
`ifdef UART_RX_MAJORITY_EN
        samp_early_d = samp_early_q;
`endif
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        par_err_d    = par_err_q;
        stop_err_d   = stop_err_q;
        any_high_d   = any_high_q;
        dataout_d    = dataout_q;
        valid_d      = valid_q;
        dataerror_d  = dataerror_q;
        frameerror_d = frameerror_q;
        overrun_d    = 1'b0;
        breakdet_d   = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            phase_d   = '0;
            bit_cnt_d = '0;
            if (fall) begin
                state_d    = ST_START;
                par_acc_d  = 1'b0;
                stop_err_d = 1'b0;
                any_high_d = 1'b0;
            end
        end else if (tick) begin
            phase_d = (phase_q == PW'(OVERSAMPLE - 1)) ? '0 : phase_q + PW'(1);
`ifdef UART_RX_MAJORITY_EN
            if (phase_q == PW'(MID - 2)) samp_early_d = rx_sync_q;
`endif
            if (phase_q == PW'(MID - 1)) samp_mid_d = rx_sync_q;
            if (phase_q == PW'(MID)) begin
                case (state_q)
                    ST_START: begin
                        state_d = bit_val ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: begin
                        shift_d    = {bit_val, shift_q[DATA_BITS-1:1]};
                        par_acc_d  = par_acc_q ^ bit_val;
                        any_high_d = any_high_now;
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        par_err_d  = (par_acc_q ^ bit_val) != (PARITY == PAR_ODD);
                        any_high_d = any_high_now;
                        state_d    = ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                            state_d = ST_IDLE;
                            if (!any_high_now) begin
                                breakdet_d = 1'b1;
                            end else if (!valid_q || ready) begin
                                valid_d      = 1'b1;
                                dataout_d    = shift_q;
                                dataerror_d  = (PARITY != PAR_NONE) && par_err_q;
                                frameerror_d = stop_err_now;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            stop_err_d = stop_err_now;
                            any_high_d = any_high_now;
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            bit_cnt_q    <= '0;
            samp_mid_q   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            samp_early_q <= 1'b1;
`endif
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            any_high_q   <= 1'b0;
            dataout_q    <= '0;
            valid_q      <= 1'b0;
            dataerror_q  <= 1'b0;
            frameerror_q <= 1'b0;
            overrun_q    <= 1'b0;
            breakdet_q   <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_mid_q   <= samp_mid_d;
`ifdef UART_RX_MAJORITY_EN
            samp_early_q <= samp_early_d;
`endif
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
            any_high_q   <= any_high_d;
            dataout_q    <= dataout_d;
            valid_q      <= valid_d;
            dataerror_q  <= dataerror_d;
            frameerror_q <= frameerror_d;
            overrun_q    <= overrun_d;
            breakdet_q   <= breakdet_d;
        end
    end

    assign dataout    = dataout_q;
    assign valid      = valid_q;
    assign dataerror  = dataerror_q;
    assign frameerror = frameerror_q;
    assign overrun    = overrun_q;
    assign breakdet   = breakdet_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed + randomized bench for uart_rx_param: an 8N1/OS16/DIV1 instance
// and a 7E2/OS8/DIV3 instance, checked against a frame-level reference model.
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_rx, a_ready, a_valid, a_de, a_fe, a_ovr, a_brk;
    logic [7:0] a_data;
    logic       b_rx, b_ready, b_valid, b_de, b_fe, b_ovr, b_brk;
    logic [6:0] b_data;

    uart_rx_param u_a (
        .clk(clk), .rst(rst), .rx(a_rx), .dataout(a_data), .valid(a_valid),
        .ready(a_ready), .dataerror(a_de), .frameerror(a_fe),
        .overrun(a_ovr), .breakdet(a_brk)
    );

    uart_rx_param #(
        .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(8), .CLK_DIV(3)
    ) u_b (
        .clk(clk), .rst(rst), .rx(b_rx), .dataout(b_data), .valid(b_valid),
        .ready(b_ready), .dataerror(b_de), .frameerror(b_fe),
        .overrun(b_ovr), .breakdet(b_brk)
    );

    int total = 0;
    int bad   = 0;

    // Event monitor: consumed words ({fe, de, data}) and pulse/valid counts.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int a_vcnt = 0, a_ocnt = 0, a_bcnt = 0;
    int b_vcnt = 0, b_ocnt = 0, b_bcnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid) a_vcnt++;
            if (a_ovr) a_ocnt++;
            if (a_brk) a_bcnt++;
            if (a_valid && a_ready) qa.push_back({6'd0, a_fe, a_de, a_data});
            if (b_valid) b_vcnt++;
            if (b_ovr) b_ocnt++;
            if (b_brk) b_bcnt++;
            if (b_valid && b_ready) qb.push_back({6'd0, b_fe, b_de, 1'b0, b_data});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) a_rx = v;
            else b_rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, then nbits of 'bits' LSB first; optional one-cycle glitch.
    task automatic send_frame(input int which, input logic [15:0] bits, input int nbits,
                              input int glitch_bit, input int glitch_off);
        int bt;
        bt = (which == 0) ? 16 : 24;
        drive(which, 1'b0, bt);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                drive(which, bits[i], glitch_off);
                drive(which, ~bits[i], 1);
                drive(which, bits[i], bt - glitch_off - 1);
            end else begin
                drive(which, bits[i], bt);
            end
        end
    endtask

    task automatic expect_frame(input int which, input string tag, input logic [7:0] d,
                                input logic de, input logic fe);
        int n;
        logic [15:0] v;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            n = (which == 0) ? qa.size() : qb.size();
            if (n > 0) break;
            @(posedge clk);
            #1;
        end
        chk($sformatf("%s_arrived", tag), 32'(n > 0), 32'd1);
        if (n > 0) begin
            if (which == 0) v = qa.pop_front();
            else v = qb.pop_front();
            $display("frame %s: data=%h de=%b fe=%b (exp %h %b %b)", tag, v[7:0], v[8], v[9], d, de, fe);
            chk($sformatf("%s_data", tag), 32'(v[7:0]), 32'(d));
            chk($sformatf("%s_de", tag), 32'(v[8]), 32'(de));
            chk($sformatf("%s_fe", tag), 32'(v[9]), 32'(fe));
        end
    endtask

    function automatic logic [15:0] a_bits(input logic [7:0] d);
        return {7'd0, 1'b1, d};
    endfunction

    function automatic logic [15:0] b_bits(input logic [6:0] d, input logic p,
                                           input logic s1, input logic s2);
        return {6'd0, s2, s1, p, d};
    endfunction

    initial begin
        int vc0, oc0, bc0;
        logic [7:0] rb;
        logic [6:0] rd;
        logic rp, rs1, rs2, exp_de;

        rst = 1'b1;
        a_rx = 1'b1; b_rx = 1'b1;
        a_ready = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_data", 32'(a_data), 32'd0);
        chk("rst_a_flags", 32'({a_de, a_fe, a_ovr, a_brk}), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_b_flags", 32'({b_de, b_fe, b_ovr, b_brk}), 32'd0);
        rst = 1'b0;
        drive(0, 1'b1, 10);

        // 8N1 single byte, consumer always ready
        a_ready = 1'b1; b_ready = 1'b1;
        vc0 = a_vcnt;
        send_frame(0, a_bits(8'hA5), 9, -1, 0);
        drive(0, 1'b1, 32);
        expect_frame(0, "a5", 8'hA5, 1'b0, 1'b0);
        chk("a5_valid_cycles", 32'(a_vcnt - vc0), 32'd1);

        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            send_frame(0, a_bits(rb), 9, -1, 0);
            drive(0, 1'b1, $urandom_range(0, 20));
            expect_frame(0, $sformatf("a_rand%0d", k), rb, 1'b0, 1'b0);
        end

        // false start: 5 low ticks then idle
        vc0 = a_vcnt;
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 40);
        chk("false_start_no_valid", 32'(a_vcnt - vc0), 32'd0);
        chk("false_start_no_word", 32'(qa.size()), 32'd0);
        send_frame(0, a_bits(8'h3C), 9, -1, 0);
        drive(0, 1'b1, 32);
        expect_frame(0, "after_false", 8'h3C, 1'b0, 1'b0);

        // one-cycle glitch exactly at the mid sample of data bit 3
        send_frame(0, a_bits(8'hFF), 9, 3, 8);
        drive(0, 1'b1, 32);
`ifdef UART_RX_MAJORITY_EN
        expect_frame(0, "glitch", 8'hFF, 1'b0, 1'b0);
`else
        expect_frame(0, "glitch", 8'hF7, 1'b0, 1'b0);
`endif

        // back-to-back with consumer stalled: first word held, one overrun
        a_ready = 1'b0;
        oc0 = a_ocnt;
        send_frame(0, a_bits(8'h11), 9, -1, 0);
        send_frame(0, a_bits(8'h22), 9, -1, 0);
        drive(0, 1'b1, 32);
        chk("ovr_valid_held", 32'(a_valid), 32'd1);
        chk("ovr_data_held", 32'(a_data), 32'h11);
        chk("ovr_pulses", 32'(a_ocnt - oc0), 32'd1);
        a_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_valid_cleared", 32'(a_valid), 32'd0);
        expect_frame(0, "ovr_word", 8'h11, 1'b0, 1'b0);
        chk("ovr_no_second", 32'(qa.size()), 32'd0);

        // asynchronous reset in the middle of a frame
        a_ready = 1'b0;
        send_frame(0, a_bits(8'h5B), 9, -1, 0);
        drive(0, 1'b1, 32);
        chk("pre_rst_valid", 32'(a_valid), 32'd1);
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 20);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(a_valid), 32'd0);
        chk("async_rst_data", 32'(a_data), 32'd0);
        a_rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b1, 40);
        a_ready = 1'b1;
        vc0 = a_vcnt;
        send_frame(0, a_bits(8'h96), 9, -1, 0);
        drive(0, 1'b1, 32);
        expect_frame(0, "post_rst", 8'h96, 1'b0, 1'b0);
        chk("post_rst_one_valid", 32'(a_vcnt - vc0), 32'd1);

        // 7E2 instance: parity checking
        drive(1, 1'b1, 48);
        send_frame(1, b_bits(7'h41, 1'b1, 1'b1, 1'b1), 10, -1, 0);
        drive(1, 1'b1, 48);
        expect_frame(1, "b41_badpar", 8'h41, 1'b1, 1'b0);
        send_frame(1, b_bits(7'h41, 1'b0, 1'b1, 1'b1), 10, -1, 0);
        drive(1, 1'b1, 48);
        expect_frame(1, "b41_goodpar", 8'h41, 1'b0, 1'b0);

        // second stop bit low
        send_frame(1, b_bits(7'h5A, 1'b0, 1'b1, 1'b0), 10, -1, 0);
        drive(1, 1'b1, 48);
        expect_frame(1, "b5a_stop2", 8'h5A, 1'b0, 1'b1);

        // break: line low for 12 bit times
        bc0 = b_bcnt;
        vc0 = b_vcnt;
        drive(1, 1'b0, 12 * 24);
        chk("brk_pulse", 32'(b_bcnt - bc0), 32'd1);
        chk("brk_no_valid", 32'(b_vcnt - vc0), 32'd0);
        drive(1, 1'b1, 48);
        chk("brk_no_word", 32'(qb.size()), 32'd0);
        send_frame(1, b_bits(7'h2B, 1'b0, 1'b1, 1'b1), 10, -1, 0);
        drive(1, 1'b1, 48);
        expect_frame(1, "after_brk", 8'h2B, 1'b0, 1'b0);

        // random 7E2 frames with random parity and stop errors
        for (int k = 0; k < 6; k++) begin
            rd  = 7'($urandom);
            rp  = 1'($urandom_range(0, 1));
            rs1 = 1'($urandom_range(0, 1));
            rs2 = 1'($urandom_range(0, 1));
            if (rd == 7'd0 && !rp && !rs1 && !rs2) rs1 = 1'b1;
            exp_de = 1'(($countones(rd) + int'(rp)) % 2);
            send_frame(1, b_bits(rd, rp, rs1, rs2), 10, -1, 0);
            drive(1, 1'b1, 48);
            expect_frame(1, $sformatf("b_rand%0d", k), {1'b0, rd}, exp_de, !(rs1 && rs2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
